// File: rtl/m68k_bus_front.sv
// m68k_bus_front: front end between the 68000 pins and the _cpu bus-cycle sequencer.
// Synchronises /AS, /UDS and /LDS, turns them into dreqin/sizin/rwin for _cpu, latches
// the address and write data, captures read data on erd, and returns /DTACK or /BERR.
//
// Ports
//   sys_clk, reset              clock (rising edge) and asynchronous active-high reset
//   cpu_asl/udsl/ldsl, cpu_rw   68000 strobes (asynchronous) and R/W (1 = read)
//   cpu_addr, cpu_dout          68000 A[23:1] and write data
//   cpu_din                     read data latch presented to the 68000
//   cpu_dtackl, cpu_berrl       /DTACK and /BERR back to the 68000, active low
//   dreqin, sizin, rwin         request set to _cpu (sizin = {UDSL,LDSL})
//   dtackl, erd                 _cpu cycle-done (active low) and read-data-valid strobe
//   bus_din                     read data from the system bus
//   bus_addr, bus_dout          byte address {A[23:1],0} and write data to the bus
//   bus_dout_oe                 write-data drive enable
module m68k_bus_front #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        cpu_asl,
    input  logic        cpu_udsl,
    input  logic        cpu_ldsl,
    input  logic        cpu_rw,
    input  logic [22:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_dtackl,
    output logic        cpu_berrl,
    output logic        dreqin,
    output logic [1:0]  sizin,
    output logic        rwin,
    input  logic        dtackl,
    input  logic        erd,
    input  logic [15:0] bus_din,
    output logic [23:0] bus_addr,
    output logic [15:0] bus_dout,
    output logic        bus_dout_oe
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_BERR,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] as_sync, uds_sync, lds_sync;
    logic                   sas, suds, slds, start;

    // Counts REQ cycles including the current one; saturates at TIMEOUT.
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic        dreqin_nxt, rwin_nxt, cpu_dtackl_nxt, cpu_berrl_nxt, bus_dout_oe_nxt;
    logic [1:0]  sizin_nxt;
    logic [15:0] cpu_din_nxt, bus_dout_nxt;
    logic [23:0] bus_addr_nxt;

    // Strobe synchronisers; idle value is 1 so reset never looks like a bus cycle.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            as_sync  <= '1;
            uds_sync <= '1;
            lds_sync <= '1;
        end else begin
            as_sync  <= {as_sync[SYNC_STAGES-2:0], cpu_asl};
            uds_sync <= {uds_sync[SYNC_STAGES-2:0], cpu_udsl};
            lds_sync <= {lds_sync[SYNC_STAGES-2:0], cpu_ldsl};
        end
    end

    assign sas   = as_sync[SYNC_STAGES-1];
    assign suds  = uds_sync[SYNC_STAGES-1];
    assign slds  = lds_sync[SYNC_STAGES-1];
    assign start = ~sas & (~suds | ~slds);

    // State and registered outputs.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dreqin      <= 1'b0;
            sizin       <= 2'b11;
            rwin        <= 1'b1;
            cpu_dtackl  <= 1'b1;
            cpu_berrl   <= 1'b1;
            cpu_din     <= '0;
            bus_addr    <= '0;
            bus_dout    <= '0;
            bus_dout_oe <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            dreqin      <= dreqin_nxt;
            sizin       <= sizin_nxt;
            rwin        <= rwin_nxt;
            cpu_dtackl  <= cpu_dtackl_nxt;
            cpu_berrl   <= cpu_berrl_nxt;
            cpu_din     <= cpu_din_nxt;
            bus_addr    <= bus_addr_nxt;
            bus_dout    <= bus_dout_nxt;
            bus_dout_oe <= bus_dout_oe_nxt;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        dreqin_nxt      = dreqin;
        sizin_nxt       = sizin;
        rwin_nxt        = rwin;
        cpu_dtackl_nxt  = cpu_dtackl;
        cpu_berrl_nxt   = cpu_berrl;
        cpu_din_nxt     = cpu_din;
        bus_addr_nxt    = bus_addr;
        bus_dout_nxt    = bus_dout;
        bus_dout_oe_nxt = bus_dout_oe;

        // Read data is only taken on read cycles so writes never disturb cpu_din.
        if ((state == ST_REQ || state == ST_ACK) && erd && rwin) begin
            cpu_din_nxt = bus_din;
        end

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    state_nxt       = ST_REQ;
                    bus_addr_nxt    = {cpu_addr, 1'b0};
                    rwin_nxt        = cpu_rw;
                    sizin_nxt       = {suds, slds};
                    bus_dout_nxt    = cpu_dout;
                    dreqin_nxt      = 1'b1;
                    bus_dout_oe_nxt = ~cpu_rw;
                    cnt_nxt         = CNT_W'(1);
                end
            end
            ST_REQ: begin
                if (cnt != TIMEOUT_C) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                // _cpu completion wins over a timeout landing on the same edge.
                if (!dtackl) begin
                    state_nxt      = ST_ACK;
                    cpu_dtackl_nxt = 1'b0;
                end else if (cnt == TIMEOUT_C) begin
                    state_nxt       = ST_BERR;
                    cpu_berrl_nxt   = 1'b0;
                    dreqin_nxt      = 1'b0;
                    bus_dout_oe_nxt = 1'b0;
                end
            end
            ST_ACK: begin
                if (sas) begin
                    state_nxt       = ST_DONE;
                    dreqin_nxt      = 1'b0;
                    cpu_dtackl_nxt  = 1'b1;
                    bus_dout_oe_nxt = 1'b0;
                    cnt_nxt         = '0;
                end
            end
            ST_BERR: begin
                if (sas) begin
                    state_nxt     = ST_DONE;
                    cpu_berrl_nxt = 1'b1;
                    cnt_nxt       = '0;
                end
            end
            ST_DONE: begin
                // Hold off any new cycle until _cpu has released dtackl.
                if (dtackl) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_m68k_bus_front.sv
// tb_m68k_bus_front: randomized self-checking bench for m68k_bus_front.
// A transaction-level model predicts, per 68000 cycle, the latched request fields,
// whether _cpu completion or the timeout ends it, and the read data the 68000 sees.
module tb_m68k_bus_front;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT     = 255;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        cpu_asl, cpu_udsl, cpu_ldsl, cpu_rw;
    logic [22:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;
    logic        cpu_dtackl, cpu_berrl;
    logic        dreqin;
    logic [1:0]  sizin;
    logic        rwin;
    logic        dtackl, erd;
    logic [15:0] bus_din;
    logic [23:0] bus_addr;
    logic [15:0] bus_dout;
    logic        bus_dout_oe;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] model_din;

    m68k_bus_front #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .cpu_asl(cpu_asl), .cpu_udsl(cpu_udsl), .cpu_ldsl(cpu_ldsl), .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .cpu_dtackl(cpu_dtackl), .cpu_berrl(cpu_berrl),
        .dreqin(dreqin), .sizin(sizin), .rwin(rwin),
        .dtackl(dtackl), .erd(erd), .bus_din(bus_din),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_dout_oe(bus_dout_oe)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return dreqin;
            1:       return cpu_dtackl;
            default: return cpu_berrl;
        endcase
    endfunction

    // Bounded wait on a DUT output; edges = negedges elapsed.
    task automatic wait_sig(input int which, input logic val, input int max_edges, output int edges);
        edges = 0;
        while (sig_sel(which) !== val && edges < max_edges) begin
            @(negedge sys_clk);
            edges++;
        end
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_dreqin"},     dreqin,      0);
        chk({p, "_sizin"},      sizin,       2'b11);
        chk({p, "_rwin"},       rwin,        1);
        chk({p, "_cpu_dtackl"}, cpu_dtackl,  1);
        chk({p, "_cpu_berrl"},  cpu_berrl,   1);
        chk({p, "_cpu_din"},    cpu_din,     0);
        chk({p, "_bus_addr"},   bus_addr,    0);
        chk({p, "_bus_dout"},   bus_dout,    0);
        chk({p, "_bus_dout_oe"}, bus_dout_oe, 0);
    endtask

    // sz is the active-low {UDS,LDS} pair the 68000 drives.
    task automatic drive_strobes(input logic rw, input logic [1:0] sz, input logic [22:0] addr,
                                 input logic [15:0] wd);
        cpu_rw   = rw;
        cpu_addr = addr;
        cpu_dout = wd;
        cpu_udsl = sz[1];
        cpu_ldsl = sz[0];
        cpu_asl  = 1'b0;
    endtask

    task automatic await_req(input int exp_lat, input logic rw, input logic [1:0] sz,
                             input logic [22:0] addr, input logic [15:0] wd);
        int   e;
        logic nrw;
        nrw = ~rw;
        wait_sig(0, 1'b1, 12, e);
        chk("req_latency", e, exp_lat);
        chk("req_dreqin", dreqin, 1);
        chk("req_sizin", sizin, sz);
        chk("req_rwin", rwin, rw);
        chk("req_bus_addr", bus_addr, {addr, 1'b0});
        chk("req_bus_dout", bus_dout, wd);
        chk("req_oe", bus_dout_oe, nrw);
    endtask

    // _cpu model: dtackl goes low at negedge ack_at (negative = never), erd pulses at erd_at.
    // Completion is taken if dtackl low is seen within the first TIMEOUT REQ cycles.
    task automatic req_phase(input logic rw, input int ack_at, input int erd_at,
                             input logic [15:0] rd);
        bit   ack, early;
        int   stop;
        logic nrw;
        ack   = (ack_at >= 0) && (ack_at < int'(TIMEOUT));
        stop  = ack ? ack_at + 1 : int'(TIMEOUT);
        early = 1'b0;
        nrw   = ~rw;
        for (int n = 0; n < stop; n++) begin
            if (cpu_dtackl !== 1'b1 || cpu_berrl !== 1'b1 || dreqin !== 1'b1) early = 1'b1;
            erd     = (n == erd_at);
            bus_din = (n == erd_at) ? rd : 16'($urandom);
            dtackl  = !(ack_at >= 0 && n >= ack_at);
            @(negedge sys_clk);
        end
        erd     = 1'b0;
        bus_din = 16'($urandom);
        if (rw && erd_at >= 0 && erd_at < stop) model_din = rd;
        chk("req_hold", early, 0);
        if (ack) begin
            chk("ack_cpu_dtackl", cpu_dtackl, 0);
            chk("ack_dreqin", dreqin, 1);
            chk("ack_cpu_berrl", cpu_berrl, 1);
            chk("ack_oe", bus_dout_oe, nrw);
        end else begin
            chk("berr_cpu_berrl", cpu_berrl, 0);
            chk("berr_dreqin", dreqin, 0);
            chk("berr_cpu_dtackl", cpu_dtackl, 1);
            chk("berr_oe", bus_dout_oe, 0);
            if (ack_at >= 0) dtackl = 1'b0;
        end
        chk("cpu_din", cpu_din, model_din);
    endtask

    task automatic release_as(input bit ack);
        int e;
        cpu_asl  = 1'b1;
        cpu_udsl = 1'b1;
        cpu_ldsl = 1'b1;
        wait_sig(ack ? 1 : 2, 1'b1, 12, e);
        chk("release_latency", e, SYNC_STAGES + 1);
        chk("rel_dreqin", dreqin, 0);
        chk("rel_cpu_dtackl", cpu_dtackl, 1);
        chk("rel_cpu_berrl", cpu_berrl, 1);
        chk("rel_oe", bus_dout_oe, 0);
    endtask

    task automatic done_phase(input int hold);
        bit spur;
        spur = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge sys_clk);
            if (dreqin !== 1'b0) spur = 1'b1;
        end
        dtackl = 1'b1;
        repeat (2) begin
            @(negedge sys_clk);
            if (dreqin !== 1'b0) spur = 1'b1;
        end
        chk("done_no_req", spur, 0);
        chk("done_cpu_din", cpu_din, model_din);
    endtask

    task automatic full_cycle(input logic rw, input logic [1:0] sz, input logic [22:0] addr,
                              input logic [15:0] wd, input int ack_at, input int erd_at,
                              input logic [15:0] rd, input int hold);
        drive_strobes(rw, sz, addr, wd);
        await_req(SYNC_STAGES + 1, rw, sz, addr, wd);
        req_phase(rw, ack_at, erd_at, rd);
        repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        release_as((ack_at >= 0) && (ack_at < int'(TIMEOUT)));
        done_phase(hold);
    endtask

    initial begin
        bit          spur;
        logic [1:0]  sz;
        logic        rw;
        int          ack_at, erd_at, stop;
        logic [22:0] addr;
        logic [15:0] wd;

        reset = 1'b1;
        cpu_asl = 1'b1; cpu_udsl = 1'b1; cpu_ldsl = 1'b1; cpu_rw = 1'b1;
        cpu_addr = '0; cpu_dout = '0;
        dtackl = 1'b1; erd = 1'b0; bus_din = '0;
        model_din = '0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Word read with erd then dtackl.
        full_cycle(1'b1, 2'b00, 23'h001234, 16'h0000, 4, 2, 16'hBEEF, 2);
        chk("word_read_addr", bus_addr, 24'h002468);
        chk("word_read_din", cpu_din, 16'hBEEF);

        // Lower-byte write; erd during a write must not touch cpu_din.
        full_cycle(1'b0, 2'b10, 23'h7ABCDE, 16'h00A5, 3, 1, 16'h1111, 1);
        chk("write_din_kept", cpu_din, 16'hBEEF);

        // AS low with both data strobes high is not a request.
        cpu_asl = 1'b0;
        spur = 1'b0;
        repeat (8) begin
            @(negedge sys_clk);
            if (dreqin !== 1'b0) spur = 1'b1;
        end
        chk("no_ds_no_req", spur, 0);
        cpu_asl = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Timeout, then the two sides of the dtackl/timeout race.
        full_cycle(1'b1, 2'b01, 23'h000100, 16'h0, -1, 10, 16'h5A5A, 0);
        full_cycle(1'b1, 2'b00, 23'h000200, 16'h0, TIMEOUT - 1, -1, 16'h0, 1);
        full_cycle(1'b0, 2'b00, 23'h000300, 16'hCAFE, TIMEOUT, -1, 16'h0, 3);

        // Back-to-back: second AS arrives while DONE waits for dtackl.
        drive_strobes(1'b1, 2'b00, 23'h011111, 16'h0);
        await_req(SYNC_STAGES + 1, 1'b1, 2'b00, 23'h011111, 16'h0);
        req_phase(1'b1, 2, 0, 16'h1234);
        release_as(1'b1);
        drive_strobes(1'b0, 2'b01, 23'h022222, 16'h9876);
        spur = 1'b0;
        repeat (6) begin
            @(negedge sys_clk);
            if (dreqin !== 1'b0) spur = 1'b1;
        end
        chk("b2b_held_off", spur, 0);
        dtackl = 1'b1;
        await_req(2, 1'b0, 2'b01, 23'h022222, 16'h9876);
        req_phase(1'b0, 5, -1, 16'h0);
        release_as(1'b1);
        done_phase(0);

        // Randomized cycles.
        for (int t = 0; t < 30; t++) begin
            rw   = 1'($urandom);
            sz   = 2'($urandom_range(0, 2));
            addr = 23'($urandom);
            wd   = 16'($urandom);
            ack_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 20));
            stop = (ack_at >= 0) ? ack_at + 1 : int'(TIMEOUT);
            erd_at = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, stop - 1)) : -1;
            full_cycle(rw, sz, addr, wd, ack_at, erd_at, 16'($urandom), int'($urandom_range(0, 4)));
        end

        // Reset while in ACK: outputs clear at once, no request afterwards with AS high.
        drive_strobes(1'b1, 2'b00, 23'h055555, 16'h0);
        await_req(SYNC_STAGES + 1, 1'b1, 2'b00, 23'h055555, 16'h0);
        req_phase(1'b1, 2, 1, 16'h4321);
        @(posedge sys_clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        model_din = '0;
        cpu_asl = 1'b1; cpu_udsl = 1'b1; cpu_ldsl = 1'b1;
        dtackl = 1'b1;
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        spur = 1'b0;
        repeat (10) begin
            @(negedge sys_clk);
            if (dreqin !== 1'b0) spur = 1'b1;
        end
        chk("post_rst_no_req", spur, 0);
        full_cycle(1'b1, 2'b10, 23'h066666, 16'h0, 1, 0, 16'h7777, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
